// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/bubble sequencer.
// Stall bit positions, register address bus width and controller state encodings.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned StallW     = 6;
  localparam int unsigned StallPC    = 0;
  localparam int unsigned StallIFID  = 1;
  localparam int unsigned StallIDEX  = 2;
  localparam int unsigned StallEXMEM = 3;
  localparam int unsigned StallWB    = 4;

  localparam int unsigned RegAddrBus = 4;
  localparam int unsigned RegZero    = 0;

  // Hold patterns: fetch-only, load-use (front three), memory freeze (all live stages)
  localparam logic [StallW-1:0] StallFetch   = StallW'(1) << StallPC;
  localparam logic [StallW-1:0] StallLoadUse = StallFetch
                                             | (StallW'(1) << StallIFID)
                                             | (StallW'(1) << StallIDEX);
  localparam logic [StallW-1:0] StallMem     = StallLoadUse
                                             | (StallW'(1) << StallEXMEM)
                                             | (StallW'(1) << StallWB);

  typedef enum logic {
    CtrlRun     = 1'b0,
    CtrlMemWait = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between ID source operands and the EX destination.
// Kept standalone so a branch-in-ID hazard check can reuse it.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = RegAddrBus,
  parameter int unsigned REG_ZERO = RegZero
) (
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              is_load,
  output logic              load_use_c
);

  logic dst_valid;
  logic hit1;
  logic hit2;

  always_comb begin
    dst_valid  = is_load && we && (waddr != ADDR_W'(REG_ZERO));
    hit1       = re1 && (raddr1 == waddr);
    hit2       = re2 && (raddr2 == waddr);
    load_use_c = dst_valid && (hit1 || hit2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline: memory structural stalls,
// load-use stalls, memory-wait timeout and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = RegAddrBus,
  parameter int unsigned REG_ZERO = RegZero,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_re1,
  input  logic [ADDR_W-1:0] id_raddr1,
  input  logic              id_re2,
  input  logic [ADDR_W-1:0] id_raddr2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic              ex_is_load,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic [StallW-1:0] stall,
  output logic              bubble_ifid,
  output logic              bubble_idex,
  output logic              bubble_memwb,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  ctrl_state_e      state;
  ctrl_state_e      next_state;
  logic [WaitW-1:0] wait_cnt;
  logic [WaitW-1:0] wait_nxt;
  logic             timeout_set;
  logic             load_use;

  hazard_detect #(
    .ADDR_W   (ADDR_W),
    .REG_ZERO (REG_ZERO)
  ) u_hazard_detect (
    .re1        (id_re1),
    .raddr1     (id_raddr1),
    .re2        (id_re2),
    .raddr2     (id_raddr2),
    .we         (ex_we),
    .waddr      (ex_waddr),
    .is_load    (ex_is_load),
    .load_use_c (load_use)
  );

  // Next state and zero-latency stage controls; memory beats load-use
  always_comb begin
    next_state   = state;
    wait_nxt     = wait_cnt;
    timeout_set  = 1'b0;
    stall        = '0;
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_memwb = 1'b0;

    case (state)
      CtrlRun: begin
        wait_nxt = '0;
        if (mem_req && mem_ready) begin
          stall       = StallFetch;
          bubble_ifid = 1'b1;
        end else if (mem_req) begin
          stall        = StallMem;
          bubble_memwb = 1'b1;
          next_state   = CtrlMemWait;
          wait_nxt     = WaitW'(1);
        end else if (load_use) begin
          stall       = StallLoadUse;
          bubble_idex = 1'b1;
        end
      end

      CtrlMemWait: begin
        if (mem_ready) begin
          stall       = StallFetch;
          bubble_ifid = 1'b1;
          next_state  = CtrlRun;
          wait_nxt    = '0;
        end else if (wait_cnt >= WaitW'(MAX_WAIT)) begin
          // Give up on the access and let fetch resume
          stall       = StallFetch;
          bubble_ifid = 1'b1;
          timeout_set = 1'b1;
          next_state  = CtrlRun;
          wait_nxt    = '0;
        end else begin
          stall        = StallMem;
          bubble_memwb = 1'b1;
          wait_nxt     = wait_cnt + WaitW'(1);
        end
      end

      default: begin
        next_state = CtrlRun;
        wait_nxt   = '0;
      end
    endcase

    if (rst) begin
      stall        = '0;
      bubble_ifid  = 1'b0;
      bubble_idex  = 1'b0;
      bubble_memwb = 1'b0;
    end
  end

  // State, wait counter, sticky timeout and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CtrlRun;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_nxt;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      if (stall[StallPC] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
